// File: rtl/fir_reload_seq.sv
// fir_reload_seq: synchronises a foreign reload strobe and sequences FIR reset, reload burst, settle delay and channel config
module fir_reload_seq #(
    parameter int SYNC_STAGES = 3,
    parameter int RST_LEN     = 5,
    parameter int BURST_LEN   = 104,
    parameter int CONF_DELAY  = 200,
    parameter int CNT_W       = 16,
    parameter int CH_W        = 2
) (
    input  logic            clk,
    input  logic            rst_ext_n,
    input  logic            in_val,
    input  logic [CH_W-1:0] in_ch,
    input  logic            err_clr,
    output logic            rel_tvalid,
    output logic            rel_tlast,
    input  logic            rel_tready,
    output logic            conf_tvalid,
    output logic [CH_W-1:0] conf_tdata,
    input  logic            conf_tready,
    output logic            rst_fir,
    output logic            busy,
    output logic            done,
    output logic            err_ovf,
    output logic            err_seq
);
    typedef enum logic [2:0] {IDLE, RST, LOAD, DELAY, CONF} state_t;
    state_t r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic r_hist, r_edge, r_rel_v, r_done, r_err_ovf, r_err_seq;
    logic [CNT_W-1:0] r_cnt;
    logic [CH_W-1:0] r_ch;
    logic w_hs, w_last, w_cnt_inc, w_ovf_set, w_seq_set;
    assign w_hs      = r_rel_v & rel_tready;
    assign w_last    = r_cnt == CNT_W'(BURST_LEN - 1);
    assign w_cnt_inc = (r_state == RST || r_state == DELAY || (r_state == LOAD && w_hs)) && !(&r_cnt);
    assign w_ovf_set = r_state == LOAD && r_edge && r_rel_v && !rel_tready;
    assign w_seq_set = r_edge && (r_state == RST || r_state == DELAY || r_state == CONF);
    // synchroniser chain, history flop and registered rising-edge pulse
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_val};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end
    // state register
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) r_state <= IDLE;
        else            r_state <= w_next;
    end
    // next-state decode; the tlast handshake ends the burst
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = r_edge ? RST : IDLE;
            RST:     w_next = (r_cnt == CNT_W'(RST_LEN - 1)) ? LOAD : RST;
            LOAD:    w_next = (w_hs && w_last) ? DELAY : LOAD;
            DELAY:   w_next = (r_cnt == CNT_W'(CONF_DELAY - 1)) ? CONF : DELAY;
            CONF:    w_next = conf_tready ? IDLE : CONF;
            default: w_next = IDLE;
        endcase
    end
    // shared saturating counter, strobe holding, channel latch, done pulse and sticky errors
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            r_cnt     <= '0;
            r_rel_v   <= 1'b0;
            r_ch      <= '0;
            r_done    <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_seq <= 1'b0;
        end else begin
            r_cnt     <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(w_cnt_inc);
            r_rel_v   <= r_state == LOAD && w_next == LOAD && (r_edge || (r_rel_v && !rel_tready));
            r_ch      <= (r_state == IDLE && r_edge) ? in_ch : r_ch;
            r_done    <= r_state == CONF && conf_tready;
            r_err_ovf <= w_ovf_set | (r_err_ovf & ~err_clr);
            r_err_seq <= w_seq_set | (r_err_seq & ~err_clr);
        end
    end
    // outputs decoded from state and registers
    always_comb begin
        rst_fir     = r_state != RST;
        busy        = r_state != IDLE;
        conf_tvalid = r_state == CONF;
        conf_tdata  = (r_state == CONF) ? r_ch : '0;
        rel_tvalid  = r_rel_v;
        rel_tlast   = r_rel_v & w_last;
        done        = r_done;
        err_ovf     = r_err_ovf;
        err_seq     = r_err_seq;
    end
endmodule

// File: tb/tb_fir_reload_seq.sv
// tb_fir_reload_seq: directed vector table plus hand sequences for the reload sequencer
module tb_fir_reload_seq;
    localparam int CH_W = 2;
    localparam logic [9:0] IDLE_O = 10'b1_0_0_0_0_00_0_0_0;
    localparam logic [9:0] RST_O  = 10'b0_1_0_0_0_00_0_0_0;
    localparam logic [9:0] LOAD_O = 10'b1_1_0_0_0_00_0_0_0;
    localparam logic [9:0] RV_O   = 10'b1_1_1_0_0_00_0_0_0;
    localparam logic [9:0] RVL_O  = 10'b1_1_1_1_0_00_0_0_0;
    localparam logic [9:0] CONF_O = 10'b1_1_0_0_1_10_0_0_0;
    localparam logic [9:0] DONE_O = 10'b1_0_0_0_0_00_1_0_0;
    logic clk = 0, rst_ext_n = 0, in_val = 0, err_clr = 0, rel_tready = 1, conf_tready = 1;
    logic [CH_W-1:0] in_ch = 2;
    logic rel_tvalid, rel_tlast, conf_tvalid, rst_fir, busy, done, err_ovf, err_seq;
    logic [CH_W-1:0] conf_tdata;
    logic [9:0] obs;
    int n_vec = 0, n_bad = 0;
    typedef struct { logic iv; int n; logic [9:0] exp; } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;
    assign obs = {rst_fir, busy, rel_tvalid, rel_tlast, conf_tvalid, conf_tdata, done, err_ovf, err_seq};

    fir_reload_seq #(.SYNC_STAGES(3), .RST_LEN(5), .BURST_LEN(4), .CONF_DELAY(10), .CNT_W(16), .CH_W(CH_W)) dut (
        .clk(clk), .rst_ext_n(rst_ext_n), .in_val(in_val), .in_ch(in_ch), .err_clr(err_clr),
        .rel_tvalid(rel_tvalid), .rel_tlast(rel_tlast), .rel_tready(rel_tready),
        .conf_tvalid(conf_tvalid), .conf_tdata(conf_tdata), .conf_tready(conf_tready),
        .rst_fir(rst_fir), .busy(busy), .done(done), .err_ovf(err_ovf), .err_seq(err_seq));

    function automatic vec_t mk(input logic iv, input int n, input logic [9:0] exp);
        vec_t v;
        v.iv = iv; v.n = n; v.exp = exp;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic start_seq(input string nm);
        in_val = 1; step(1); in_val = 0;
        step(4); chk({nm, " rst_fir low"}, rst_fir, 0);
        step(5); chk({nm, " load entry"}, {rst_fir, busy, rel_tvalid}, 3'b110);
    endtask

    task automatic strobe(input string nm, input logic last);
        in_val = 1; step(1); in_val = 0;
        step(4); chk({nm, " tvalid/tlast"}, {rel_tvalid, rel_tlast}, {1'b1, last});
        step(1); chk({nm, " tvalid drop"}, rel_tvalid, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) tbl.push_back(mk(0, 1 + k, IDLE_O));
        tbl.push_back(mk(1, 1, IDLE_O));
        tbl.push_back(mk(0, 3, IDLE_O));
        tbl.push_back(mk(0, 1, RST_O));
        tbl.push_back(mk(0, 4, RST_O));
        tbl.push_back(mk(0, 1, LOAD_O));
        for (int k = 1; k <= 4; k++) begin
            tbl.push_back(mk(1, 1, LOAD_O));
            tbl.push_back(mk(0, 3, LOAD_O));
            tbl.push_back(mk(0, 1, (k == 4) ? RVL_O : RV_O));
            tbl.push_back(mk(0, 1, LOAD_O));
        end
        tbl.push_back(mk(0, 9, LOAD_O));
        tbl.push_back(mk(0, 1, CONF_O));
        tbl.push_back(mk(0, 1, DONE_O));
        tbl.push_back(mk(0, 1, IDLE_O));

        @(negedge clk); @(negedge clk);
        chk("reset outputs", obs, IDLE_O);
        rst_ext_n = 1;
        foreach (tbl[i]) begin
            in_val = tbl[i].iv;
            step(tbl[i].n);
            chk($sformatf("vec%0d", i), obs, tbl[i].exp);
        end
        in_val = 0;

        // overflow: second edge while strobe 2 is stalled
        start_seq("ovf");
        strobe("ovf s1", 0);
        rel_tready = 0;
        in_val = 1; step(1); in_val = 0; step(4);
        chk("ovf s2 pending", rel_tvalid, 1);
        in_val = 1; step(1); in_val = 0; step(3);
        chk("ovf not yet", err_ovf, 0);
        step(1); chk("ovf set", {err_ovf, rel_tvalid}, 2'b11);
        step(10); chk("ovf held", {rel_tvalid, rel_tlast}, 2'b10);
        rel_tready = 1; step(1);
        chk("ovf s2 accepted", rel_tvalid, 0);
        strobe("ovf s3", 0);
        strobe("ovf s4", 1);
        step(10); chk("ovf conf", {conf_tvalid, conf_tdata}, 3'b110);
        step(1); chk("ovf done", {done, busy, err_ovf}, 3'b101);

        // sequence error during DELAY, timing unaffected
        start_seq("seq");
        strobe("seq s1", 0); strobe("seq s2", 0); strobe("seq s3", 0); strobe("seq s4", 1);
        in_val = 1; step(1); in_val = 0; step(4);
        chk("seq err set", {err_seq, conf_tvalid}, 2'b10);
        step(4); chk("seq conf early", conf_tvalid, 0);
        step(1); chk("seq conf on time", conf_tvalid, 1);
        step(1); chk("seq done", done, 1);
        chk("errs before clr", {err_ovf, err_seq}, 2'b11);
        err_clr = 1; step(1); err_clr = 0;
        chk("errs cleared", {err_ovf, err_seq}, 2'b00);

        // conf back-pressure, channel latched at start only
        in_ch = 1; conf_tready = 0;
        start_seq("bp");
        in_ch = 3;
        strobe("bp s1", 0); strobe("bp s2", 0); strobe("bp s3", 0); strobe("bp s4", 1);
        step(10); chk("bp conf up", {conf_tvalid, conf_tdata}, 3'b101);
        step(7); chk("bp conf held", {conf_tvalid, conf_tdata, done}, 4'b1010);
        conf_tready = 1; step(1);
        chk("bp handshake", {conf_tvalid, done, busy}, 3'b010);

        // reset mid-LOAD, then a clean full sequence
        in_ch = 0;
        start_seq("abort");
        rel_tready = 0;
        in_val = 1; step(1); in_val = 0; step(4);
        chk("abort pending", rel_tvalid, 1);
        rst_ext_n = 0; #1;
        chk("abort async", obs, IDLE_O);
        step(2); rst_ext_n = 1; rel_tready = 1;
        step(3); chk("abort idle", obs, IDLE_O);
        start_seq("rerun");
        strobe("rerun s1", 0); strobe("rerun s2", 0); strobe("rerun s3", 0); strobe("rerun s4", 1);
        step(10); chk("rerun conf", {conf_tvalid, conf_tdata}, 3'b100);
        step(1); chk("rerun done", {done, busy}, 2'b10);

        // sub-cycle glitch never sampled
        #1 in_val = 1; #2 in_val = 0;
        step(10); chk("glitch ignored", busy, 0);

        // in_val high across reset release and for 50 cycles: one edge only
        rst_ext_n = 0; in_val = 1; step(1); rst_ext_n = 1;
        step(4); chk("hold no edge yet", busy, 0);
        step(1); chk("hold edge", {busy, rst_fir}, 2'b10);
        step(45); chk("hold single edge", {busy, rel_tvalid, err_seq, err_ovf}, 4'b1000);
        in_val = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_reload_seq.md
FIR_RELOAD_SEQ -- requirements
Module: fir_reload_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3, synchroniser depth for in_val (legal range 2..4).
REQ-002 SHALL have parameter RST_LEN, default 5, number of cycles rst_fir is held low.
REQ-003 SHALL have parameter BURST_LEN, default 104, number of reload strobes per sequence (legal range 1..2^CNT_W-1).
REQ-004 SHALL have parameter CONF_DELAY, default 200, cycles from last reload handshake to conf_tvalid.
REQ-005 SHALL have parameter CNT_W, default 16, width of all internal counters.
REQ-006 SHALL have parameter CH_W, default 2, width of channel index.
REQ-007 SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-008 SHALL have port rst_ext_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port in_val, input, 1, asynchronous reload strobe from foreign domain.
REQ-010 SHALL have port in_ch, input, CH_W, target channel, quasi-static, sampled on sequence start.
REQ-011 SHALL have port err_clr, input, 1, synchronous clear of sticky errors.
REQ-012 SHALL have ports rel_tvalid, rel_tlast (outputs, 1) and rel_tready (input, 1), the reload stream.
REQ-013 SHALL have ports conf_tvalid (output, 1), conf_tdata (output, CH_W) and conf_tready (input, 1), the config stream.
REQ-014 SHALL have output ports rst_fir (1, active-low FIR reset), busy (1), done (1), err_ovf (1), err_seq (1).

Function
REQ-015 SHALL pass in_val through a SYNC_STAGES-deep flop chain plus one history flop; one internal edge pulse per synchronised 0->1 transition.
REQ-016 SHALL implement states IDLE, RST, LOAD, DELAY, CONF.
REQ-017 SHALL transition IDLE->RST on an edge, latch in_ch, and consume the edge without a reload strobe.
REQ-018 SHALL drive rst_fir low for exactly RST_LEN cycles in RST, then enter LOAD.
REQ-019 SHALL, in LOAD, raise rel_tvalid the cycle after each edge and hold it until rel_tvalid&rel_tready.
REQ-020 SHALL assert rel_tlast together with rel_tvalid for the BURST_LEN-th strobe only.
REQ-021 SHALL enter DELAY on the handshake of the tlast strobe and reset its counter to 0.
REQ-022 SHALL enter CONF after exactly CONF_DELAY cycles in DELAY, driving conf_tvalid=1 and conf_tdata=latched channel, held until conf_tready.
REQ-023 SHALL, on the conf handshake, return to IDLE and pulse done for one cycle.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL, on an edge while a reload strobe is pending and not handshaking that cycle, set err_ovf sticky; the new strobe is dropped and the count is unchanged.
REQ-026 SHALL, on an edge coincident with the handshake of a pending strobe, accept the new strobe with no error.
REQ-027 SHALL, on an edge in RST, DELAY or CONF, ignore the edge and set err_seq sticky.
REQ-028 SHALL clear err_ovf/err_seq on err_clr; a set in the same cycle SHALL win.
REQ-029 SHALL count with CNT_W-bit counters without wrap; a counter reaching its terminal value SHALL stop.
REQ-030 SHALL add no other latency: edge-to-rel_tvalid SHALL be SYNC_STAGES+2 clocks from first clk sampling in_val high.

Reset
REQ-031 SHALL, on rst_ext_n low, immediately force state IDLE, all counters 0, sync chain and history 0, rst_fir=1, and rel_tvalid, rel_tlast, conf_tvalid, busy, done, err_ovf, err_seq=0, conf_tdata=0.
REQ-032 SHALL abort any sequence in progress on reset with no partial output after release.
REQ-033 SHALL, if in_val is high at reset release, detect one edge after SYNC_STAGES+1 cycles.

Verification (SYNC_STAGES=3, RST_LEN=5, BURST_LEN=4, CONF_DELAY=10, CH_W=2)
REQ-034 SHALL cover: in_ch=2, 5 in_val pulses with tready=1 -> rst_fir low 5 cycles, 4 rel_tvalid pulses with tlast on 4th, conf_tvalid 10 cycles after last, conf_tdata=2, done pulse.
REQ-035 SHALL cover: rel_tready=0 for 20 cycles while 2nd strobe pending and another edge arrives -> err_ovf=1, count unchanged, tlast still on 4th accepted strobe.
REQ-036 SHALL cover: edge during DELAY -> err_seq=1, conf timing unchanged; err_clr -> both errors 0.
REQ-037 SHALL cover: conf_tready low 7 cycles -> conf_tvalid held 8 cycles, stable conf_tdata, then IDLE.
REQ-038 SHALL cover: rst_ext_n low mid-LOAD -> all outputs at reset values same cycle; next sequence after release runs complete from RST.
REQ-039 SHALL cover: in_val glitch shorter than one clk, and in_val held high 50 cycles -> at most one edge each.
